// File: rtl/seq_div16.sv
// seq_div16 - sequential restoring divider for the ALU execute stage.
//
// Computes one quotient bit per clock with a shift / trial-subtract step
// and returns quotient and remainder over a start/done handshake. Signed
// operands are divided as magnitudes and the signs are applied at the end.
// This gives truncating division, and the remainder takes the sign of the
// dividend.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while idle
//   mode       0 = unsigned, 1 = signed two's complement (sampled with start)
//   dividend   numerator (sampled with start)
//   divisor    denominator (sampled with start)
//   quotient   registered quotient, held until the next done
//   remainder  registered remainder, held until the next done
//   busy       high while a division is in progress
//   done       one-cycle pulse when results are updated
//   divByZero  status of the last result: divisor was zero
//   overflow   status of the last result: signed 16'h8000 / -1
module seq_div16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] dvsrReg;
  logic             qneg;
  logic             rneg;
  logic             dzReg;
  logic             ovfReg;

  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             ovfDetect;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Operand magnitudes. Signs are only stripped in signed mode, so in
  // unsigned mode the raw bit patterns go straight into the datapath.
  always_comb begin
    magA      = (mode && dividend[WIDTH-1]) ? -dividend : dividend;
    magB      = (mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    ovfDetect = mode && (dividend == MIN_NEG) && (divisor == '1);
  end

  // One restoring step. The partial remainder shifts left and takes in the
  // next dividend bit from the top of the quotient register. The shifted
  // value needs 17 bits because it can reach twice the divisor. When the
  // trial subtraction succeeds, the difference is always below the divisor,
  // so it fits back into 16 bits.
  always_comb begin
    shifted = {remReg, quoReg[WIDTH-1]};
    fits    = shifted >= {1'b0, dvsrReg};
    diff    = shifted - {1'b0, dvsrReg};
  end

  // Control FSM and datapath registers. All outputs are registered here.
  // For divide-by-zero, the raw dividend is parked in the quotient register
  // so that FIX can return it unchanged as the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      remReg    <= '0;
      quoReg    <= '0;
      dvsrReg   <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      dzReg     <= 1'b0;
      ovfReg    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            qneg   <= mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg   <= mode & dividend[WIDTH-1];
            remReg <= '0;
            count  <= '0;
            busy   <= 1'b1;
            ovfReg <= ovfDetect;
            if (divisor == '0) begin
              dzReg   <= 1'b1;
              quoReg  <= dividend;
              dvsrReg <= '0;
              state   <= FIX;
            end else begin
              dzReg   <= 1'b0;
              quoReg  <= magA;
              dvsrReg <= magB;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          quoReg <= {quoReg[WIDTH-2:0], fits};
          remReg <= fits ? WIDTH'(diff) : shifted[WIDTH-1:0];
          count  <= count + CNT_ONE;
          if (count == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dzReg) begin
            quotient  <= '1;
            remainder <= quoReg;
          end else begin
            quotient  <= qneg ? -quoReg : quoReg;
            remainder <= rneg ? -remReg : remReg;
          end
          divByZero <= dzReg;
          overflow  <= ovfReg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16 - scoreboard bench for seq_div16.
//
// The stimulus process issues directed divisions with hand-computed
// results and pushes each expectation, including the cycle in which done
// must appear, into a queue. A separate monitor pops and compares entries
// whenever done is seen.
module tb_seq_div16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic        overflow;

  int cycle = 0;
  int tests = 0;
  int fails = 0;
  int bc;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  seq_div16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .overflow  (overflow)
  );

  // Free-running clock and an edge counter used to time done.
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle. The expected done cycle is the
  // accepting edge plus the latency in edges. After the request, the
  // operands are scrambled to show that they are latched.
  task automatic applyStimulus(input string name, input logic m, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                               input logic edz, input logic eovf, input int lat, input bit push);
    exp_t e;
    mode     = m;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.name = name;
      e.q    = eq;
      e.r    = er;
      e.dz   = edz;
      e.ovf  = eovf;
      e.cyc  = cycle + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    mode     = 1'($urandom);
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  // Wait for done with a cycle bound and count the cycles in which busy is
  // high. With poke set, start is raised with junk operands while busy.
  task automatic waitDone(input string name, input bit poke, output int busyCycles);
    busyCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busyCycles++;
      if (done) begin
        start = 1'b0;
        return;
      end
      if (poke && busy) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({name, " done timeout"}, {31'b0, done}, 32'd1);
  endtask

  // Monitor: each done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("spurious done", {31'b0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, " quotient"}, {16'b0, quotient}, {16'b0, e.q});
          checkOutput({e.name, " remainder"}, {16'b0, remainder}, {16'b0, e.r});
          checkOutput({e.name, " divByZero"}, {31'b0, divByZero}, {31'b0, e.dz});
          checkOutput({e.name, " overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
          checkOutput({e.name, " done cycle"}, cycle, e.cyc);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset quotient", {16'b0, quotient}, 32'd0);
    checkOutput("reset remainder", {16'b0, remainder}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset divByZero", {31'b0, divByZero}, 32'd0);
    checkOutput("reset overflow", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unsigned basic case, with start poked while busy.
    applyStimulus("t1 1000/7", 1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t1", 1'b1, bc);
    checkOutput("t1 busy cycles", bc, 32'd17);
    @(negedge clk);

    // Signed cases across sign combinations, and the same bits unsigned.
    applyStimulus("t2 -7/2", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t2", 1'b0, bc);
    applyStimulus("s 7/-2", 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17, 1'b1);
    waitDone("s1", 1'b0, bc);
    applyStimulus("s -8/-3", 1'b1, 16'hFFF8, 16'hFFFD, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 17, 1'b1);
    waitDone("s2", 1'b0, bc);
    applyStimulus("u 65529/2", 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 1'b0, 17, 1'b1);
    waitDone("u1", 1'b0, bc);
    @(negedge clk);

    // Divide by zero, unsigned and signed: the raw dividend is returned.
    applyStimulus("t3 1234/0", 1'b0, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 1, 1'b1);
    waitDone("t3", 1'b0, bc);
    checkOutput("t3 busy cycles", bc, 32'd1);
    applyStimulus("dz signed -7/0", 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0, 1, 1'b1);
    waitDone("dz2", 1'b0, bc);
    @(negedge clk);

    // Signed overflow, then cases that must clear the overflow flag.
    applyStimulus("t4 8000/FFFF", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 17, 1'b1);
    waitDone("t4", 1'b0, bc);
    applyStimulus("t4 65535/1", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t4b", 1'b0, bc);
    applyStimulus("u 8000/FFFF", 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 17, 1'b1);
    waitDone("u2", 1'b0, bc);
    repeat (3) @(negedge clk);

    // Back-to-back: the second start is raised in the done cycle.
    applyStimulus("t5 100/3", 1'b0, 16'd100, 16'd3, 16'd33, 16'd1, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t5a", 1'b0, bc);
    applyStimulus("t5 9/9", 1'b0, 16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t5b", 1'b0, bc);
    @(negedge clk);

    // Reset in the middle of a division aborts it without a done.
    applyStimulus("t6 abort", 1'b0, 16'd50000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0, 17, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 reset busy", {31'b0, busy}, 32'd0);
    checkOutput("t6 reset done", {31'b0, done}, 32'd0);
    checkOutput("t6 reset quotient", {16'b0, quotient}, 32'd0);
    checkOutput("t6 reset remainder", {16'b0, remainder}, 32'd0);
    checkOutput("t6 reset divByZero", {31'b0, divByZero}, 32'd0);
    checkOutput("t6 reset overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("t6 idle busy", {31'b0, busy}, 32'd0);
    applyStimulus("t6 50000/3", 1'b0, 16'd50000, 16'd3, 16'd16666, 16'd2, 1'b0, 1'b0, 17, 1'b1);
    waitDone("t6", 1'b0, bc);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
